qr_cordic_sched: RTL and testbench

- Sequencer that time-shares one pipelined CORDIC core across the 13 Givens steps of a 2x2 complex QR decomposition, which also applies Q^H to Y.
- Sits between the detector top level and the shared CORDIC/register-file datapath.
- Issues each micro-op, holds dependent ops until the pipeline drains, and generates delayed register-file and angle write strobes.
- Provides a start/busy/done handshake to the top level.

---
 rtl/qr_sched_pkg.sv | 97 +++++++++
 rtl/qr_wb_delay.sv | 52 +++++
 rtl/qr_cordic_sched.sv | 139 +++++++++++++
 tb/tb_qr_cordic_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/qr_sched_pkg.sv
// qr_sched_pkg
// Shared definitions for the 2x2 complex QR Givens sequencer:
//   - register-file address map (H11..Y2 plus pair-view temporaries)
//   - angle register indices
//   - micro-op struct and the 13-entry micro-program ROM
//   - writeback tag carried alongside the CORDIC pipeline
//   - sequencer state enum
// Ports: none (package).
package qr_sched_pkg;

  localparam int QR_AW   = 4;
  localparam int QR_NOPS = 13;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  // Matrix and observation entries. The layout is pair-aligned: (H11,H21),
  // (H12,H22) and (Y1,Y2) each occupy one even/odd address pair.
  localparam logic [QR_AW-1:0] ADDR_H11 = 4'd0;
  localparam logic [QR_AW-1:0] ADDR_H21 = 4'd1;
  localparam logic [QR_AW-1:0] ADDR_H12 = 4'd2;
  localparam logic [QR_AW-1:0] ADDR_H22 = 4'd3;
  localparam logic [QR_AW-1:0] ADDR_Y1  = 4'd4;
  localparam logic [QR_AW-1:0] ADDR_Y2  = 4'd5;

  // Temporaries used as real-valued pair views by the datapath. Each one
  // names a 2-vector that a single CORDIC pass vectors or rotates.
  localparam logic [QR_AW-1:0] ADDR_T_HMAG = 4'd6;   // (|h11|, |h21|)
  localparam logic [QR_AW-1:0] ADDR_T_H2RE = 4'd7;   // (re h12, re h22)
  localparam logic [QR_AW-1:0] ADDR_T_H2IM = 4'd8;   // (im h12, im h22)
  localparam logic [QR_AW-1:0] ADDR_T_YRE  = 4'd9;   // (re y1, re y2)
  localparam logic [QR_AW-1:0] ADDR_T_YIM  = 4'd10;  // (im y1, im y2)
  localparam logic [QR_AW-1:0] ADDR_T_H22P = 4'd11;  // h22' after column step
  localparam logic [QR_AW-1:0] ADDR_T_Y2P  = 4'd12;  // y2' after column step

  // Angle registers written by vectoring passes, read by rotations.
  localparam logic [1:0] ANG_H11  = 2'd0;
  localparam logic [1:0] ANG_H21  = 2'd1;
  localparam logic [1:0] ANG_COL  = 2'd2;
  localparam logic [1:0] ANG_H22P = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // dep: op must wait until no earlier op is in the CORDIC pipeline.
  typedef struct packed {
    logic             mode;
    logic [QR_AW-1:0] src;
    logic [1:0]       ang_sel;
    logic [QR_AW-1:0] dst;
    logic [1:0]       ang_dst;
    logic             dep;
  } uop_t;

  typedef struct packed {
    logic             valid;
    logic             mode;
    logic [QR_AW-1:0] dst;
    logic [1:0]       ang_dst;
  } wb_tag_t;

  //                      mode      src          ang_sel   dst          ang_dst   dep
  localparam uop_t UOP_ROM [QR_NOPS] = '{
    '{MODE_VEC, ADDR_H11,    ANG_H11,  ADDR_H11,    ANG_H11,  1'b0},  // 0  V(h11)
    '{MODE_ROT, ADDR_H12,    ANG_H11,  ADDR_H12,    2'd0,     1'b1},  // 1  R(h12)
    '{MODE_ROT, ADDR_Y1,     ANG_H11,  ADDR_Y1,     2'd0,     1'b0},  // 2  R(y1)
    '{MODE_VEC, ADDR_H21,    ANG_H11,  ADDR_H21,    ANG_H21,  1'b0},  // 3  V(h21)
    '{MODE_ROT, ADDR_H22,    ANG_H21,  ADDR_H22,    2'd0,     1'b1},  // 4  R(h22)
    '{MODE_ROT, ADDR_Y2,     ANG_H21,  ADDR_Y2,     2'd0,     1'b0},  // 5  R(y2)
    '{MODE_VEC, ADDR_T_HMAG, ANG_H11,  ADDR_T_HMAG, ANG_COL,  1'b1},  // 6  V(|h11|,|h21|)
    '{MODE_ROT, ADDR_T_H2RE, ANG_COL,  ADDR_T_H2RE, 2'd0,     1'b1},  // 7  R(re h12,h22)
    '{MODE_ROT, ADDR_T_H2IM, ANG_COL,  ADDR_T_H2IM, 2'd0,     1'b0},  // 8  R(im h12,h22)
    '{MODE_ROT, ADDR_T_YRE,  ANG_COL,  ADDR_T_YRE,  2'd0,     1'b0},  // 9  R(re y1,y2)
    '{MODE_ROT, ADDR_T_YIM,  ANG_COL,  ADDR_T_YIM,  2'd0,     1'b0},  // 10 R(im y1,y2)
    '{MODE_VEC, ADDR_T_H22P, ANG_H11,  ADDR_T_H22P, ANG_H22P, 1'b1},  // 11 V(h22')
    '{MODE_ROT, ADDR_T_Y2P,  ANG_H22P, ADDR_T_Y2P,  2'd0,     1'b1}   // 12 R(y2')
  };

  // Vectoring ops never read an angle; their ang_sel field is forced to 0
  // so the CORDIC select bus only toggles for rotations.
  function automatic uop_t uop_fetch(input logic [3:0] idx);
    uop_fetch = '0;
    for (int k = 0; k < QR_NOPS; k++) begin
      if (idx == 4'(k)) begin
        uop_fetch = UOP_ROM[k];
      end
    end
    if (uop_fetch.mode == MODE_VEC) begin
      uop_fetch.ang_sel = 2'd0;
    end
  endfunction

endpackage

// File: rtl/qr_wb_delay.sv
// qr_wb_delay
// LAT-stage shift register that carries the writeback tag of each issued
// CORDIC op so that its register-file/angle write emerges exactly LAT
// cycles after issue.
// Ports:
//   i_clk            clock
//   i_rst_n          synchronous active-low reset, flushes every stage
//   i_tag            tag entering the pipeline this cycle (valid=0 if none)
//   o_tag            tag leaving the pipeline (drives the write strobes)
//   o_any_valid      some stage holds an in-flight op
//   o_upstream_valid some stage other than the last holds an op, i.e. the
//                    pipeline is not empty after the next shift
module qr_wb_delay
  import qr_sched_pkg::*;
#(
  parameter int LAT = 16
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  wb_tag_t i_tag,
  output wb_tag_t o_tag,
  output logic    o_any_valid,
  output logic    o_upstream_valid
);

  logic [LAT-1:0] w_valid;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      wb_tag_t r_tag;
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) r_tag <= '0;
          else          r_tag <= i_tag;
        end
      end else begin : g_tail
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) r_tag <= '0;
          else          r_tag <= g_stage[gi-1].r_tag;
        end
      end
      assign w_valid[gi] = r_tag.valid;
    end
  endgenerate

  assign o_tag            = g_stage[LAT-1].r_tag;
  assign o_any_valid      = |w_valid;
  // Mask off the output stage; for LAT=1 this is always 0.
  assign o_upstream_valid = |(w_valid & ~(LAT'(1) << (LAT - 1)));

endmodule

// File: rtl/qr_cordic_sched.sv
// qr_cordic_sched
// Sequencer that time-shares one pipelined CORDIC across the 13 Givens
// micro-ops of a 2x2 complex QR decomposition (Q^H also applied to Y).
// Ports:
//   CLK_100MHZ  clock, rising edge
//   rst_n       synchronous active-low reset
//   start       run request, accepted only in IDLE
//   busy        high from the cycle after start through the DONE cycle
//   done        one-cycle pulse after the final writeback
//   cd_valid    CORDIC issue strobe; cd_mode/cd_src/cd_ang_sel qualify it
//   rf_we       register-file write, LAT cycles after the matching issue
//   rf_waddr    register-file destination, aligned with rf_we
//   ang_we      angle-register write (vectoring writebacks only)
//   ang_waddr   angle-register index, aligned with ang_we
module qr_cordic_sched
  import qr_sched_pkg::*;
#(
  parameter int LAT  = 16,
  parameter int AW   = QR_AW,
  parameter int NOPS = QR_NOPS
) (
  input  logic          CLK_100MHZ,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cd_valid,
  output logic          cd_mode,
  output logic [AW-1:0] cd_src,
  output logic [1:0]    cd_ang_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic          ang_we,
  output logic [1:0]    ang_waddr
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_ptr;
  logic [3:0] w_ptr_next;
  uop_t       w_uop;
  wb_tag_t    w_tag_in;
  wb_tag_t    w_tag_out;
  logic       w_any_valid;
  logic       w_upstream_valid;

  assign w_uop = uop_fetch(r_ptr);

  always_ff @(posedge CLK_100MHZ) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    busy         = 1'b0;
    done         = 1'b0;
    cd_valid     = 1'b0;
    cd_mode      = 1'b0;
    cd_src       = '0;
    cd_ang_sel   = 2'd0;
    w_tag_in     = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_ISSUE;
          w_ptr_next   = 4'd0;
        end
      end

      ST_ISSUE: begin
        busy = 1'b1;
        // Dependent ops stall until every earlier op has written back;
        // independent ops stream one per cycle.
        if (!w_uop.dep || !w_any_valid) begin
          cd_valid         = 1'b1;
          cd_mode          = w_uop.mode;
          cd_src           = w_uop.src;
          cd_ang_sel       = w_uop.ang_sel;
          w_tag_in.valid   = 1'b1;
          w_tag_in.mode    = w_uop.mode;
          w_tag_in.dst     = w_uop.dst;
          w_tag_in.ang_dst = (w_uop.mode == MODE_VEC) ? w_uop.ang_dst : 2'd0;
          if (r_ptr == 4'(NOPS - 1)) begin
            w_state_next = ST_DRAIN;
            w_ptr_next   = 4'd0;
          end else begin
            w_ptr_next = r_ptr + 4'd1;
          end
        end
      end

      ST_DRAIN: begin
        busy = 1'b1;
        // Leave one cycle early so DONE lands on the first empty cycle,
        // right after the last writeback.
        if (!w_upstream_valid) begin
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  qr_wb_delay #(
    .LAT(LAT)
  ) u_wb_delay (
    .i_clk            (CLK_100MHZ),
    .i_rst_n          (rst_n),
    .i_tag            (w_tag_in),
    .o_tag            (w_tag_out),
    .o_any_valid      (w_any_valid),
    .o_upstream_valid (w_upstream_valid)
  );

  // Tags are zero-filled when not valid, so the address buses stay 0
  // between writebacks.
  assign rf_we     = w_tag_out.valid;
  assign rf_waddr  = w_tag_out.dst;
  assign ang_we    = w_tag_out.valid && (w_tag_out.mode == MODE_VEC);
  assign ang_waddr = ang_we ? w_tag_out.ang_dst : 2'd0;

endmodule

// File: tb/tb_qr_cordic_sched.sv
// tb_qr_cordic_sched
// Drives a LAT=16 and a LAT=1 instance of qr_cordic_sched from the same
// start/rst_n and compares every output, every cycle, against a schedule
// derived from the micro-program's dependency rule.
module tb_qr_cordic_sched;

  logic clk;
  logic rst_n;
  logic start;

  logic       busy_a, done_a, cdv_a, cdm_a, rfwe_a, angwe_a;
  logic [3:0] cds_a, rfwa_a;
  logic [1:0] cda_a, angwa_a;
  logic       busy_b, done_b, cdv_b, cdm_b, rfwe_b, angwe_b;
  logic [3:0] cds_b, rfwa_b;
  logic [1:0] cda_b, angwa_b;

  qr_cordic_sched #(.LAT(16)) dut_a (
    .CLK_100MHZ (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy_a),
    .done       (done_a),
    .cd_valid   (cdv_a),
    .cd_mode    (cdm_a),
    .cd_src     (cds_a),
    .cd_ang_sel (cda_a),
    .rf_we      (rfwe_a),
    .rf_waddr   (rfwa_a),
    .ang_we     (angwe_a),
    .ang_waddr  (angwa_a)
  );

  qr_cordic_sched #(.LAT(1)) dut_b (
    .CLK_100MHZ (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy_b),
    .done       (done_b),
    .cd_valid   (cdv_b),
    .cd_mode    (cdm_b),
    .cd_src     (cds_b),
    .cd_ang_sel (cda_b),
    .rf_we      (rfwe_b),
    .rf_waddr   (rfwa_b),
    .ang_we     (angwe_b),
    .ang_waddr  (angwa_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Micro-program as written down from the algorithm: mode (0=V, 1=R),
  // operand, angle read, destination, angle write, wait flag.
  int t_mode   [13] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
  int t_src    [13] = '{0, 2, 4, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
  int t_angsel [13] = '{0, 0, 0, 0, 1, 1, 0, 2, 2, 2, 2, 0, 3};
  int t_dst    [13] = '{0, 2, 4, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
  int t_angdst [13] = '{0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0};
  int t_wait   [13] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};

  int lat_of [2] = '{16, 1};
  int sched  [2][13];
  int done_c [2];
  bit active [2];
  int rel    [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Issue times relative to the start cycle: each op follows its
  // predecessor by one cycle; a waiting op additionally needs every
  // earlier op out of the pipeline (in flight t0..t0+L).
  task automatic build_schedule();
    for (int d = 0; d < 2; d++) begin
      int t = 0;
      int last = 0;
      for (int j = 0; j < 13; j++) begin
        t = t + 1;
        if (t_wait[j] != 0 && j > 0 && t < last + lat_of[d] + 1)
          t = last + lat_of[d] + 1;
        sched[d][j] = t;
        last = t;
      end
      done_c[d] = last + lat_of[d] + 1;
      active[d] = 1'b0;
      rel[d]    = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic bsy, input logic dn,
                           input logic cv, input logic cm, input logic [3:0] cs,
                           input logic [1:0] ca, input logic we, input logic [3:0] wa,
                           input logic awe, input logic [1:0] awa);
    int e_busy = 0, e_done = 0, e_cv = 0, e_cm = 0, e_cs = 0, e_ca = 0;
    int e_we = 0, e_wa = 0, e_awe = 0, e_awa = 0;
    string p;
    p = $sformatf("L%0d", lat_of[d]);
    if (active[d]) begin
      e_busy = 1;
      e_done = (rel[d] == done_c[d]) ? 1 : 0;
      for (int j = 0; j < 13; j++) begin
        if (sched[d][j] == rel[d]) begin
          e_cv = 1; e_cm = t_mode[j]; e_cs = t_src[j]; e_ca = t_angsel[j];
        end
        if (sched[d][j] + lat_of[d] == rel[d]) begin
          e_we = 1; e_wa = t_dst[j];
          if (t_mode[j] == 0) begin
            e_awe = 1; e_awa = t_angdst[j];
          end
        end
      end
    end
    check({p, " busy"},       int'(bsy), e_busy);
    check({p, " done"},       int'(dn),  e_done);
    check({p, " cd_valid"},   int'(cv),  e_cv);
    check({p, " cd_mode"},    int'(cm),  e_cm);
    check({p, " cd_src"},     int'(cs),  e_cs);
    check({p, " cd_ang_sel"}, int'(ca),  e_ca);
    check({p, " rf_we"},      int'(we),  e_we);
    check({p, " rf_waddr"},   int'(wa),  e_wa);
    check({p, " ang_we"},     int'(awe), e_awe);
    check({p, " ang_waddr"},  int'(awa), e_awa);
  endtask

  // One cycle: check this cycle's outputs, then apply this cycle's inputs
  // and advance the reference to the next cycle.
  task automatic step(input logic st, input logic rn);
    @(negedge clk);
    check_dut(0, busy_a, done_a, cdv_a, cdm_a, cds_a, cda_a, rfwe_a, rfwa_a, angwe_a, angwa_a);
    check_dut(1, busy_b, done_b, cdv_b, cdm_b, cds_b, cda_b, rfwe_b, rfwa_b, angwe_b, angwa_b);
    start = st;
    rst_n = rn;
    for (int d = 0; d < 2; d++) begin
      if (!rn) begin
        if (active[d]) $display("[TB] L%0d run aborted by reset at cycle %0d", lat_of[d], cyc);
        active[d] = 1'b0;
      end else if (active[d]) begin
        if (rel[d] == done_c[d]) begin
          active[d] = 1'b0;
          $display("[TB] L%0d run complete, done at cycle %0d", lat_of[d], cyc);
        end else begin
          rel[d] = rel[d] + 1;
        end
      end else if (st) begin
        active[d] = 1'b1;
        rel[d]    = 1;
      end
    end
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    build_schedule();

    // Reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Nominal run with start pulses while busy and one right after IDLE
    step(1'b1, 1'b1);
    for (int c = 1; c <= 140; c++)
      step((c == 5 || c == 126 || c == 127) ? 1'b1 : 1'b0, 1'b1);
    for (int c = 0; c < 140; c++) step(1'b0, 1'b1);

    // Reset mid-run at cycle 40, then a fresh full run
    step(1'b1, 1'b1);
    for (int c = 1; c < 40; c++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int c = 0; c < 30; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int c = 0; c < 140; c++) step(1'b0, 1'b1);

    // Idle stability
    step(1'b0, 1'b0);
    for (int c = 0; c < 1000; c++) step(1'b0, 1'b1);

    // Random start pulses and occasional resets
    for (int c = 0; c < 4000; c++)
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
